// File: rtl/alu_arbiter_if.sv
// Bundle of client request ports, ALU-side ports and result/status ports for alu_arbiter.
// The master side is the environment (clients plus ALU); the slave side is the arbiter.
interface alu_arbiter_if;
  logic       req0;
  logic [3:0] op0;
  logic [7:0] a0;
  logic [7:0] b0;
  logic       req1;
  logic [3:0] op1;
  logic [7:0] a1;
  logic [7:0] b1;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_cl;
  logic [7:0] alu_out;
  logic [7:0] res;
  logic       res_valid;
  logic       res_id;
  logic       err;
  logic       busy;
  logic [7:0] op_count;

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1, alu_out,
    input  gnt0, gnt1, alu_a, alu_b, alu_cl, res, res_valid, res_id, err, busy, op_count
  );

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1, alu_out,
    output gnt0, gnt1, alu_a, alu_b, alu_cl, res, res_valid, res_id, err, busy, op_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit ALU between two requesters;
// holds the granted operands for ISSUE_WAIT cycles, then returns the tagged result.
module alu_arbiter #(
  parameter int         ISSUE_WAIT = 1,
  parameter logic [3:0] DIV_OP     = 4'b0011
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_last, r_id;
  logic [3:0] r_cnt;
  logic       r_gnt0, r_gnt1, r_res_valid, r_err, r_res_id;
  logic [7:0] r_alu_a, r_alu_b, r_res, r_op_count;
  logic [3:0] r_alu_cl;

  logic       w_sel_vld, w_sel_id, w_done;
  logic [7:0] w_sel_a, w_sel_b;
  logic [3:0] w_sel_cl;

  function automatic logic is_div0(input logic [3:0] cl, input logic [7:0] b);
    return (cl == DIV_OP) && (b == 8'd0);
  endfunction

  assign w_done = (r_state == EXEC) && (r_cnt == 4'(ISSUE_WAIT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_sel_vld   = 1'b0;
    w_sel_id    = 1'b0;
    unique case (r_state)
      IDLE: begin
        // On a tie the requester that did not win last time goes next.
        if (bus.req0 && bus.req1) begin
          w_sel_vld = 1'b1;
          w_sel_id  = ~r_last;
        end else if (bus.req0) begin
          w_sel_vld = 1'b1;
          w_sel_id  = 1'b0;
        end else if (bus.req1) begin
          w_sel_vld = 1'b1;
          w_sel_id  = 1'b1;
        end
        if (w_sel_vld) w_state_nxt = EXEC;
      end
      EXEC: begin
        if (w_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_sel_a  = w_sel_id ? bus.a1  : bus.a0;
    w_sel_b  = w_sel_id ? bus.b1  : bus.b0;
    w_sel_cl = w_sel_id ? bus.op1 : bus.op0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_cnt       <= 4'd0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_alu_a     <= 8'd0;
      r_alu_b     <= 8'd0;
      r_alu_cl    <= 4'd0;
      r_res       <= 8'd0;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_err       <= 1'b0;
      r_op_count  <= 8'd0;
    end else begin
      r_gnt0      <= w_sel_vld & ~w_sel_id;
      r_gnt1      <= w_sel_vld &  w_sel_id;
      r_res_valid <= w_done;
      r_err       <= w_done & is_div0(r_alu_cl, r_alu_b);
      if (w_sel_vld) begin
        r_alu_a  <= w_sel_a;
        r_alu_b  <= w_sel_b;
        r_alu_cl <= w_sel_cl;
        r_last   <= w_sel_id;
        r_id     <= w_sel_id;
        r_cnt    <= 4'd0;
      end else if (r_state == EXEC) begin
        r_cnt <= r_cnt + 4'd1;
      end
      // Capture stage: a trapped divide never looks at alu_out.
      if (w_done) begin
        r_res      <= is_div0(r_alu_cl, r_alu_b) ? 8'hFF : bus.alu_out;
        r_res_id   <= r_id;
        r_op_count <= r_op_count + 8'd1;
      end
    end
  end

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_cl    = r_alu_cl;
  assign bus.res       = r_res;
  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.err       = r_err;
  assign bus.busy      = (r_state == EXEC);
  assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (ISSUE_WAIT 1 and 4) share one stimulus stream
// and are each compared every cycle against a transaction-level reference model.
module tb_alu_arbiter;

  localparam logic [3:0] DIV_OP = 4'b0011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if if_w1 ();
  alu_arbiter_if if_w4 ();

  alu_arbiter #(.ISSUE_WAIT(1), .DIV_OP(DIV_OP)) dut_w1 (.clk(clk), .rst(rst), .bus(if_w1.slave));
  alu_arbiter #(.ISSUE_WAIT(4), .DIV_OP(DIV_OP)) dut_w4 (.clk(clk), .rst(rst), .bus(if_w4.slave));

  // Environment ALU; divide by zero yields 0 so a trapped 8'hFF is distinguishable.
  function automatic logic [7:0] alu_fn(input logic [3:0] cl, input logic [7:0] a, input logic [7:0] b);
    case (cl)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return (b == 8'd0) ? 8'd0 : a / b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      default: return a;
    endcase
  endfunction

  assign if_w1.alu_out = alu_fn(if_w1.alu_cl, if_w1.alu_a, if_w1.alu_b);
  assign if_w4.alu_out = alu_fn(if_w4.alu_cl, if_w4.alu_a, if_w4.alu_b);

  // Shared stimulus
  logic       s_req0, s_req1;
  logic [3:0] s_op0, s_op1;
  logic [7:0] s_a0, s_b0, s_a1, s_b1;

  assign if_w1.req0 = s_req0; assign if_w1.op0 = s_op0; assign if_w1.a0 = s_a0; assign if_w1.b0 = s_b0;
  assign if_w1.req1 = s_req1; assign if_w1.op1 = s_op1; assign if_w1.a1 = s_a1; assign if_w1.b1 = s_b1;
  assign if_w4.req0 = s_req0; assign if_w4.op0 = s_op0; assign if_w4.a0 = s_a0; assign if_w4.b0 = s_b0;
  assign if_w4.req1 = s_req1; assign if_w4.op1 = s_op1; assign if_w4.a1 = s_a1; assign if_w4.b1 = s_b1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model, one slot per instance: [0] -> ISSUE_WAIT 1, [1] -> ISSUE_WAIT 4
  int         m_wait [2] = '{1, 4};
  int         m_left [2];
  logic       m_last [2];
  logic       m_id   [2];
  logic [7:0] m_a [2], m_b [2];
  logic [3:0] m_cl [2];
  logic       e_g0 [2], e_g1 [2], e_busy [2], e_rv [2], e_err [2], e_rid [2];
  logic [7:0] e_res [2], e_cnt [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_last[k] = 1'b1; m_id[k] = 1'b0;
      m_a[k] = 8'd0; m_b[k] = 8'd0; m_cl[k] = 4'd0;
      e_g0[k] = 1'b0; e_g1[k] = 1'b0; e_busy[k] = 1'b0; e_rv[k] = 1'b0; e_err[k] = 1'b0;
      e_rid[k] = 1'b0; e_res[k] = 8'd0; e_cnt[k] = 8'd0;
    end
  endtask

  // Advance the model by one clock using the inputs presented before the edge.
  task automatic model_step(input int k);
    logic pick;
    e_g0[k] = 1'b0; e_g1[k] = 1'b0; e_rv[k] = 1'b0; e_err[k] = 1'b0;
    if (m_left[k] == 0) begin
      if (s_req0 || s_req1) begin
        pick = (s_req0 && s_req1) ? !m_last[k] : s_req1;
        m_last[k] = pick; m_id[k] = pick;
        m_a[k]  = pick ? s_a1  : s_a0;
        m_b[k]  = pick ? s_b1  : s_b0;
        m_cl[k] = pick ? s_op1 : s_op0;
        m_left[k] = m_wait[k];
        if (pick) e_g1[k] = 1'b1; else e_g0[k] = 1'b1;
      end
    end else begin
      m_left[k]--;
      if (m_left[k] == 0) begin
        e_rv[k] = 1'b1;
        e_rid[k] = m_id[k];
        e_cnt[k] = e_cnt[k] + 8'd1;
        if (m_cl[k] == DIV_OP && m_b[k] == 8'd0) begin
          e_res[k] = 8'hFF; e_err[k] = 1'b1;
        end else begin
          e_res[k] = alu_fn(m_cl[k], m_a[k], m_b[k]);
        end
      end
    end
    e_busy[k] = (m_left[k] != 0);
  endtask

  task automatic check_inst(input int k, input logic g0, input logic g1, input logic busy,
                            input logic rv, input logic err, input logic [7:0] res, input logic rid,
                            input logic [7:0] cnt, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] cl);
    string p;
    p = $sformatf("w%0d_", m_wait[k]);
    chk({p, "gnt0"}, 32'(g0), 32'(e_g0[k]));
    chk({p, "gnt1"}, 32'(g1), 32'(e_g1[k]));
    chk({p, "busy"}, 32'(busy), 32'(e_busy[k]));
    chk({p, "res_valid"}, 32'(rv), 32'(e_rv[k]));
    chk({p, "err"}, 32'(err), 32'(e_err[k]));
    chk({p, "res"}, 32'(res), 32'(e_res[k]));
    chk({p, "res_id"}, 32'(rid), 32'(e_rid[k]));
    chk({p, "op_count"}, 32'(cnt), 32'(e_cnt[k]));
    chk({p, "alu_a"}, 32'(a), 32'(m_a[k]));
    chk({p, "alu_b"}, 32'(b), 32'(m_b[k]));
    chk({p, "alu_cl"}, 32'(cl), 32'(m_cl[k]));
  endtask

  task automatic check_all();
    check_inst(0, if_w1.gnt0, if_w1.gnt1, if_w1.busy, if_w1.res_valid, if_w1.err, if_w1.res,
               if_w1.res_id, if_w1.op_count, if_w1.alu_a, if_w1.alu_b, if_w1.alu_cl);
    check_inst(1, if_w4.gnt0, if_w4.gnt1, if_w4.busy, if_w4.res_valid, if_w4.err, if_w4.res,
               if_w4.res_id, if_w4.op_count, if_w4.alu_a, if_w4.alu_b, if_w4.alu_cl);
  endtask

  task automatic drive(input logic r0, input logic r1, input logic [3:0] o0, input logic [7:0] a0,
                       input logic [7:0] b0, input logic [3:0] o1, input logic [7:0] a1,
                       input logic [7:0] b1);
    s_req0 = r0; s_op0 = o0; s_a0 = a0; s_b0 = b0;
    s_req1 = r1; s_op1 = o1; s_a1 = a1; s_b1 = b1;
  endtask

  // Called at a falling edge: step the model, clock once, check, return at the next falling edge.
  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 4'd0, 8'd0, 8'd0, 4'd0, 8'd0, 8'd0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    drive(1'b0, 1'b0, 4'd0, 8'd0, 8'd0, 4'd0, 8'd0, 8'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Single op 20 + 22
    drive(1'b1, 1'b0, 4'd0, 8'd20, 8'd22, 4'd0, 8'd0, 8'd0);
    cycle();
    chk("single_gnt0", 32'(if_w1.gnt0), 32'd1);
    chk("single_alu_a", 32'(if_w1.alu_a), 32'd20);
    drive(1'b0, 1'b0, 4'd0, 8'd0, 8'd0, 4'd0, 8'd0, 8'd0);
    cycle();
    chk("single_res", 32'(if_w1.res), 32'd42);
    chk("single_count", 32'(if_w1.op_count), 32'd1);
    idle(4);

    // Tie: both held, subtract
    drive(1'b1, 1'b1, 4'd1, 8'd10, 8'd3, 4'd1, 8'd9, 8'd4);
    for (int i = 0; i < 12; i++) cycle();
    idle(5);

    // Divide by zero then a legal divide
    drive(1'b0, 1'b1, 4'd0, 8'd0, 8'd0, DIV_OP, 8'd50, 8'd0);
    cycle();
    idle(1);
    chk("div0_res", 32'(if_w1.res), 32'hFF);
    chk("div0_err", 32'(if_w1.err), 32'd1);
    chk("div0_id", 32'(if_w1.res_id), 32'd1);
    idle(4);
    drive(1'b0, 1'b1, 4'd0, 8'd0, 8'd0, DIV_OP, 8'd50, 8'd5);
    cycle();
    idle(1);
    chk("div_res", 32'(if_w1.res), 32'd10);
    chk("div_err", 32'(if_w1.err), 32'd0);
    idle(4);

    // Random traffic; long enough for op_count to wrap on the ISSUE_WAIT=1 instance
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 6)), 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
            4'($urandom_range(0, 6)), 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
      cycle();
    end
    idle(5);

    // Asynchronous reset in the middle of EXEC
    drive(1'b1, 1'b1, 4'd0, 8'd7, 8'd8, 4'd0, 8'd1, 8'd2);
    cycle();
    chk("pre_rst_busy", 32'(if_w4.busy), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    chk("post_rst_gnt0", 32'(if_w4.gnt0), 32'd1);
    chk("post_rst_gnt1", 32'(if_w4.gnt1), 32'd0);
    for (int i = 0; i < 10; i++) cycle();
    idle(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
